display_channel_scheduler: RTL

- Time-shares the single 4-digit seven-segment display between N_CH independent value sources (8-bit two's complement each).
- Grants the display to one requesting channel at a time, round-robin, with a minimum dwell period per grant.
- Drives the 8-bit value input of the full seven-segment display block, plus one-hot grant and status outputs for LEDs and debug.

---
 rtl/display_channel_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/display_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : display_channel_scheduler
// Description : Round-robin time-sharing of one display among N_CH sources,
//               with a minimum dwell per grant and an early release path.
// Revision    : 1.0 - initial release
// ============================================================================
module display_channel_scheduler #(
  parameter int N_CH         = 4,
  parameter int W            = 8,
  parameter int DWELL_CYCLES = 100000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH*W-1:0] values,
  input  logic              hold,
  output logic [W-1:0]      value_out,
  output logic [N_CH-1:0]   grant,
  output logic              active,
  output logic              switch_pulse
);

  localparam int c_ptr_w = $clog2(N_CH);
  localparam int c_cnt_w = $clog2(DWELL_CYCLES);
  localparam logic [c_cnt_w-1:0] c_load    = c_cnt_w'(DWELL_CYCLES - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_rst = c_ptr_w'(N_CH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_ptr_w-1:0]  r_ptr, w_ptr_nxt;
  logic [N_CH-1:0]     r_grant, w_grant_nxt;
  logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
  logic [W-1:0]        r_value, w_value_nxt;
  logic                r_active, r_pulse, w_pulse_nxt;

  logic                w_found, w_take, w_cur_req;
  logic [c_ptr_w-1:0]  w_win;
  logic [c_ptr_w:0]    w_sum;
  logic [W-1:0]        w_cur_val, w_win_val;

  // Search starts just after the last winner, so the current owner is
  // considered last and wins only when nobody else is asking.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      w_sum = {1'b0, r_ptr} + (c_ptr_w + 1)'(k);
      if (w_sum >= (c_ptr_w + 1)'(N_CH)) begin
        w_sum = w_sum - (c_ptr_w + 1)'(N_CH);
      end
      if (!w_found && req[w_sum[c_ptr_w-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[c_ptr_w-1:0];
      end
    end
  end

  assign w_cur_req = |(req & r_grant);
  assign w_cur_val = values[r_ptr*W +: W];
  assign w_win_val = values[w_win*W +: W];

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_value_nxt = r_value;
    w_pulse_nxt = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_take = 1'b1;
      end
      ST_SHOW: begin
        if (!w_cur_req) begin
          if (w_found) begin
            w_take = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_value_nxt = '0;
          end
        end else if (r_cnt == '0 && !hold) begin
          // Expiry with no competitor: keep the owner and restart the dwell.
          if (w_win != r_ptr) begin
            w_take = 1'b1;
          end else begin
            w_cnt_nxt   = c_load;
            w_value_nxt = w_cur_val;
          end
        end else begin
          if (!hold && r_cnt != '0) w_cnt_nxt = r_cnt - c_cnt_w'(1);
          w_value_nxt = w_cur_val;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_value_nxt = '0;
      end
    endcase
    if (w_take) begin
      w_state_nxt = ST_SHOW;
      w_ptr_nxt   = w_win;
      w_grant_nxt = N_CH'(1) << w_win;
      w_cnt_nxt   = c_load;
      w_value_nxt = w_win_val;
      w_pulse_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ptr    <= c_ptr_rst;
      r_grant  <= '0;
      r_cnt    <= '0;
      r_value  <= '0;
      r_active <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_grant  <= w_grant_nxt;
      r_cnt    <= w_cnt_nxt;
      r_value  <= w_value_nxt;
      r_active <= (w_state_nxt == ST_SHOW);
      r_pulse  <= w_pulse_nxt;
    end
  end

  assign value_out    = r_value;
  assign grant        = r_grant;
  assign active       = r_active;
  assign switch_pulse = r_pulse;

endmodule
`default_nettype wire
